// File: rtl/core_types_pkg.sv
// Shared core types: the machine word, the memory arbiter state encoding
// and the default I$ starvation bound used by the arbiter.
package core_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_starve_counter.sv
// Saturating count of consecutive D$ grants taken while an I$ read was
// waiting. When it reaches LIMIT the arbiter lets the I$ go first.
module mem_arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clear,
  input  logic         incr,
  output logic [W-1:0] count,
  output logic         at_limit
);

  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  assign at_limit = (count == LIMIT_W);

  // Clear wins over increment; increment stops once the bound is reached.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && !at_limit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory port arbiter between the I$ fill path and the D$ fill/writeback
// path. D$ normally wins, but a bounded starvation counter forces the I$
// ahead after STARVE_LIMIT consecutive D$ grants. A grant is held until the
// memory reports ready or the requester withdraws. While the core controller
// asks for halt, no new I$ grants are issued so the D$ can flush.
import core_types_pkg::*;

module mem_arbiter #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  output logic  DUT_error,
  // I$ side
  input  logic  icache_mem_REN,
  input  word_t icache_mem_addr,
  output word_t icache_mem_load,
  output logic  icache_mem_wait,
  // D$ side
  input  logic  dcache_mem_REN,
  input  logic  dcache_mem_WEN,
  input  word_t dcache_mem_addr,
  input  word_t dcache_mem_store,
  output word_t dcache_mem_load,
  output logic  dcache_mem_wait,
  // core controller
  input  logic  core_control_halt,
  // memory side
  output logic  mem_REN,
  output logic  mem_WEN,
  output word_t mem_addr,
  output word_t mem_store,
  input  word_t mem_load,
  input  logic  mem_ready,
  output logic  mem_busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t state;
  arb_state_t next_state;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic enter_i;
  logic enter_d;
  logic starve_incr;
  logic starve_clear;
  logic starve_at_limit;
  logic illegal;
  logic illegal_q;
  logic [SW-1:0] starve_count;

  assign i_req   = icache_mem_REN;
  assign d_req   = dcache_mem_REN | dcache_mem_WEN;
  assign illegal = dcache_mem_REN & dcache_mem_WEN;
  assign grant_i = (state == GRANT_I);
  assign grant_d = (state == GRANT_D);

  // Entering a grant from IDLE is what drives the starvation bookkeeping.
  assign enter_i = (state == IDLE) && (next_state == GRANT_I);
  assign enter_d = (state == IDLE) && (next_state == GRANT_D);

  // Only D$ wins that actually held back a grantable I$ read count as
  // starvation; during halt the I$ is not grantable, so the count stays 0.
  assign starve_incr  = enter_d & i_req & ~core_control_halt;
  assign starve_clear = enter_i | core_control_halt;

  mem_arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (SW)
  ) u_starve (
    .CLK      (CLK),
    .nRST     (nRST),
    .clear    (starve_clear),
    .incr     (starve_incr),
    .count    (starve_count),
    .at_limit (starve_at_limit)
  );

  // State register; reset returns to IDLE at once so strobes drop
  // without waiting for a clock edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: IDLE picks a requester, a grant ends on ready or withdrawal.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_req && !starve_at_limit) begin
          next_state = GRANT_D;
        end else if (i_req && !core_control_halt) begin
          next_state = GRANT_I;
        end else if (d_req) begin
          next_state = GRANT_D;
        end else begin
          next_state = IDLE;
        end
      end
      GRANT_I: begin
        if (!i_req || mem_ready) begin
          next_state = IDLE;
        end
      end
      GRANT_D: begin
        if (!d_req || mem_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Memory strobes follow the granted requester; a D$ write suppresses
  // its read so an illegal REN+WEN pair reaches memory as a write only.
  always_comb begin
    mem_REN   = 1'b0;
    mem_WEN   = 1'b0;
    mem_addr  = '0;
    mem_store = '0;
    if (grant_i) begin
      mem_REN  = icache_mem_REN;
      mem_addr = icache_mem_addr;
    end else if (grant_d) begin
      mem_WEN   = dcache_mem_WEN;
      mem_REN   = dcache_mem_REN & ~dcache_mem_WEN;
      mem_addr  = dcache_mem_addr;
      mem_store = dcache_mem_store;
    end
  end

  // Requester handshake: wait until the granted access completes, and
  // return load data only in the completing cycle.
  always_comb begin
    icache_mem_wait = i_req & ~(grant_i & mem_ready);
    dcache_mem_wait = d_req & ~(grant_d & mem_ready);
    icache_mem_load = '0;
    dcache_mem_load = '0;
    if (grant_i && i_req && mem_ready) begin
      icache_mem_load = mem_load;
    end
    if (grant_d && d_req && mem_ready) begin
      dcache_mem_load = mem_load;
    end
  end

  assign mem_busy = (state != IDLE);

  // One error pulse per illegal D$ request, even if it is held for many
  // cycles while waiting on the memory.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      illegal_q <= 1'b0;
      DUT_error <= 1'b0;
    end else begin
      illegal_q <= illegal;
      DUT_error <= illegal & ~illegal_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single I$ read, D$ priority, starvation
// bound, halt/flush, illegal request, abort and reset mid-grant.
import core_types_pkg::*;

module tb_mem_arbiter;

  logic  CLK;
  logic  nRST;
  logic  DUT_error;
  logic  icache_mem_REN;
  word_t icache_mem_addr;
  word_t icache_mem_load;
  logic  icache_mem_wait;
  logic  dcache_mem_REN;
  logic  dcache_mem_WEN;
  word_t dcache_mem_addr;
  word_t dcache_mem_store;
  word_t dcache_mem_load;
  logic  dcache_mem_wait;
  logic  core_control_halt;
  logic  mem_REN;
  logic  mem_WEN;
  word_t mem_addr;
  word_t mem_store;
  word_t mem_load;
  logic  mem_ready;
  logic  mem_busy;

  int checkCount = 0;
  int failCount  = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .DUT_error         (DUT_error),
    .icache_mem_REN    (icache_mem_REN),
    .icache_mem_addr   (icache_mem_addr),
    .icache_mem_load   (icache_mem_load),
    .icache_mem_wait   (icache_mem_wait),
    .dcache_mem_REN    (dcache_mem_REN),
    .dcache_mem_WEN    (dcache_mem_WEN),
    .dcache_mem_addr   (dcache_mem_addr),
    .dcache_mem_store  (dcache_mem_store),
    .dcache_mem_load   (dcache_mem_load),
    .dcache_mem_wait   (dcache_mem_wait),
    .core_control_halt (core_control_halt),
    .mem_REN           (mem_REN),
    .mem_WEN           (mem_WEN),
    .mem_addr          (mem_addr),
    .mem_store         (mem_store),
    .mem_load          (mem_load),
    .mem_ready         (mem_ready),
    .mem_busy          (mem_busy)
  );

  // 10-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input word_t ia, input logic dr, input logic dw,
                               input word_t da, input word_t ds, input logic hl);
    icache_mem_REN    = ir;
    icache_mem_addr   = ia;
    dcache_mem_REN    = dr;
    dcache_mem_WEN    = dw;
    dcache_mem_addr   = da;
    dcache_mem_store  = ds;
    core_control_halt = hl;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    $display("[TB] start");
    nRST      = 1'b0;
    mem_ready = 1'b0;
    mem_load  = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    checkOutput("rst_busy", 32'(mem_busy), 32'd0);
    checkOutput("rst_ren", 32'(mem_REN), 32'd0);
    checkOutput("rst_wen", 32'(mem_WEN), 32'd0);
    checkOutput("rst_err", 32'(DUT_error), 32'd0);
    step();
    step();
    nRST = 1'b1;
    step();

    // I$ read at 0x40, ready two cycles after grant
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    checkOutput("i_idle_wait", 32'(icache_mem_wait), 32'd1);
    checkOutput("i_idle_ren", 32'(mem_REN), 32'd0);
    step();
    checkOutput("i_n1_ren", 32'(mem_REN), 32'd1);
    checkOutput("i_n1_addr", mem_addr, 32'h40);
    checkOutput("i_n1_busy", 32'(mem_busy), 32'd1);
    checkOutput("i_n1_load", icache_mem_load, 32'd0);
    step();
    checkOutput("i_n2_ren", 32'(mem_REN), 32'd1);
    checkOutput("i_n2_wait", 32'(icache_mem_wait), 32'd1);
    step();
    mem_ready = 1'b1;
    mem_load  = 32'h1234_5678;
    settle();
    checkOutput("i_n3_ren", 32'(mem_REN), 32'd1);
    checkOutput("i_n3_load", icache_mem_load, 32'h1234_5678);
    checkOutput("i_n3_wait", 32'(icache_mem_wait), 32'd0);
    checkOutput("i_n3_dload", dcache_mem_load, 32'd0);
    step();
    mem_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    checkOutput("i_n4_busy", 32'(mem_busy), 32'd0);
    step();

    // Both request: D$ write first, then I$ after one idle cycle
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
    step();
    checkOutput("pri_wen", 32'(mem_WEN), 32'd1);
    checkOutput("pri_ren", 32'(mem_REN), 32'd0);
    checkOutput("pri_addr", mem_addr, 32'h100);
    checkOutput("pri_store", mem_store, 32'hDEAD_BEEF);
    checkOutput("pri_iwait", 32'(icache_mem_wait), 32'd1);
    mem_ready = 1'b1;
    settle();
    checkOutput("pri_dwait", 32'(dcache_mem_wait), 32'd0);
    step();
    mem_ready = 1'b0;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, 1'b0);
    settle();
    checkOutput("pri_gap_busy", 32'(mem_busy), 32'd0);
    checkOutput("pri_gap_ren", 32'(mem_REN), 32'd0);
    step();
    checkOutput("pri_i_ren", 32'(mem_REN), 32'd1);
    checkOutput("pri_i_addr", mem_addr, 32'h80);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    step();

    // Starvation bound: four D$ reads, then the I$, then D$ again
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, '0, 1'b0);
    for (int g = 0; g < 6; g++) begin
      step();
      checkOutput($sformatf("starve_g%0d_addr", g), mem_addr, (g == 4) ? 32'h200 : 32'h300);
      checkOutput($sformatf("starve_g%0d_ren", g), 32'(mem_REN), 32'd1);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      settle();
      checkOutput($sformatf("starve_g%0d_idle", g), 32'(mem_busy), 32'd0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    step();

    // Halt during GRANT_I: finish it, serve the flush, hold off the I$
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b0);
    step();
    core_control_halt = 1'b1;
    settle();
    checkOutput("halt_i_ren", 32'(mem_REN), 32'd1);
    step();
    mem_ready = 1'b1;
    mem_load  = 32'h0BAD_F00D;
    settle();
    checkOutput("halt_i_load", icache_mem_load, 32'h0BAD_F00D);
    step();
    mem_ready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      applyStimulus(1'b1, 32'h400, 1'b0, 1'b1, 32'h500 + 32'(f), 32'hA5A5_0000 + 32'(f), 1'b1);
      step();
      checkOutput($sformatf("flush%0d_wen", f), 32'(mem_WEN), 32'd1);
      checkOutput($sformatf("flush%0d_addr", f), mem_addr, 32'h500 + 32'(f));
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
    end
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b1);
    step();
    step();
    checkOutput("halt_hold_busy", 32'(mem_busy), 32'd0);
    checkOutput("halt_hold_ren", 32'(mem_REN), 32'd0);
    core_control_halt = 1'b0;
    step();
    checkOutput("unhalt_ren", 32'(mem_REN), 32'd1);
    checkOutput("unhalt_addr", mem_addr, 32'h400);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    step();

    // Illegal D$ REN+WEN: write only, one-cycle error pulse
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h600, 32'h77, 1'b0);
    settle();
    checkOutput("ill_err_pre", 32'(DUT_error), 32'd0);
    step();
    checkOutput("ill_wen", 32'(mem_WEN), 32'd1);
    checkOutput("ill_ren", 32'(mem_REN), 32'd0);
    checkOutput("ill_err", 32'(DUT_error), 32'd1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("ill_err_off", 32'(DUT_error), 32'd0);
    step();
    checkOutput("ill_err_off2", 32'(DUT_error), 32'd0);

    // Abort: D$ withdraws its write before ready
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h700, 32'h99, 1'b0);
    step();
    checkOutput("abort_wen_on", 32'(mem_WEN), 32'd1);
    step();
    dcache_mem_WEN = 1'b0;
    settle();
    checkOutput("abort_wen", 32'(mem_WEN), 32'd0);
    checkOutput("abort_ren", 32'(mem_REN), 32'd0);
    checkOutput("abort_wait", 32'(dcache_mem_wait), 32'd0);
    checkOutput("abort_load", dcache_mem_load, 32'd0);
    step();
    checkOutput("abort_idle", 32'(mem_busy), 32'd0);

    // Reset pulse mid-GRANT_I
    applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, '0, '0, 1'b0);
    step();
    checkOutput("rstmid_ren_on", 32'(mem_REN), 32'd1);
    nRST      = 1'b0;
    mem_ready = 1'b1;
    mem_load  = 32'hCAFE_0001;
    settle();
    checkOutput("rstmid_ren", 32'(mem_REN), 32'd0);
    checkOutput("rstmid_busy", 32'(mem_busy), 32'd0);
    checkOutput("rstmid_load", icache_mem_load, 32'd0);
    checkOutput("rstmid_wait", 32'(icache_mem_wait), 32'd1);
    step();
    mem_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    nRST = 1'b1;
    step();
    checkOutput("post_rst_busy", 32'(mem_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between the I$ fill path (driven by the fetch unit's I$) and the D$ fill/writeback path. Arbitrates with D$ priority and a bounded I$ starvation counter, holds each grant until the memory completes, and blocks new I$ grants while the core controller requests halt so the D$ can flush. Sits between the two caches and the bus/memory controller inside core.

## Interface
- STARVE_LIMIT, default 4: consecutive D$ grants with an I$ request pending before I$ is forced ahead.
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- DUT_error  out  1  registered; set for one cycle on an illegal request (D$ REN and WEN together)
- icache_mem_REN  in  1  I$ read request
- icache_mem_addr  in  32 (word_t)  I$ word address
- icache_mem_load  out  32  read data to I$
- icache_mem_wait  out  1  I$ request not yet complete
- dcache_mem_REN  in  1  D$ read request
- dcache_mem_WEN  in  1  D$ write request
- dcache_mem_addr  in  32  D$ word address
- dcache_mem_store  in  32  D$ write data
- dcache_mem_load  out  32  read data to D$
- dcache_mem_wait  out  1  D$ request not yet complete
- core_control_halt  in  1  stop granting I$
- mem_REN / mem_WEN  out  1 each  memory strobes
- mem_addr  out  32  memory address
- mem_store  out  32  memory write data
- mem_load  in  32  memory read data
- mem_ready  in  1  memory completes the access this cycle
- mem_busy  out  1  state != IDLE

## Operation
- States: IDLE, GRANT_I, GRANT_D. Reset: IDLE, starve_count = 0, DUT_error = 0.
- IDLE: no memory strobes. Next state by priority: D$ request (REN|WEN) and starve_count < STARVE_LIMIT -> GRANT_D; I$ REN and ~core_control_halt -> GRANT_I; any D$ request -> GRANT_D; else IDLE.
- GRANT_x: mem_REN/mem_WEN/mem_addr/mem_store driven combinationally from the granted requester; the ungranted one sees zero strobes.
- D$ WEN has precedence over REN: mem_WEN = 1, mem_REN = 0. DUT_error pulses the cycle after REN & WEN.
- Completion: GRANT_x with mem_ready -> granted requester sees wait = 0 and load = mem_load this cycle; next state IDLE.
- Abort: granted requester drops its strobes before mem_ready -> strobes drop the same cycle, next state IDLE, no completion.
- wait = request active & ~(granted & mem_ready); it is 1 in IDLE whenever that requester is requesting. Loads are 0 when not completing.
- starve_count: on entering GRANT_D with I$ REN high and halt low, increments, saturating at STARVE_LIMIT. Cleared on entering GRANT_I and while core_control_halt is high. Width: $clog2(STARVE_LIMIT+1).
- Halt: a GRANT_I in progress finishes; after that no I$ grants. D$ is served normally so the flush completes. Deasserting halt re-enables I$ arbitration in the next IDLE.

## Timing
- Request seen in IDLE at cycle N -> strobes at memory at N+1. The earliest completion is N+1 (mem_ready at N+1). There is one mandatory idle cycle between back-to-back grants.
- Outputs other than DUT_error and mem_busy are combinational from state, requests, and mem inputs. There are no comb paths from mem_ready to mem strobes.
- nRST assertion mid-grant: IDLE immediately, strobes drop asynchronously, no completion is reported.

## Structure
- arb_state_t (IDLE/GRANT_I/GRANT_D) and the STARVE_LIMIT default go in core_types_pkg. word_t is reused.
- Single module. An optional sub-module mem_arb_starve_counter holds the saturating counter.

## Test plan
- I$ REN only, addr 0x40, mem_ready 2 cycles after grant -> mem_REN high for cycles N+1..N+3, icache_mem_load = mem_load and wait = 0 at N+3, mem_busy low at N+4.
- I$ and D$ (WEN, addr 0x100, store 0xDEADBEEF) both requesting -> GRANT_D first. mem_WEN=1, mem_store=0xDEADBEEF. I$ is granted after D$ completes plus one IDLE cycle.
- D$ requesting back-to-back with I$ pending, STARVE_LIMIT=4 -> 4 D$ grants, then the 5th grant goes to I$ and starve_count returns to 0.
- core_control_halt asserted during GRANT_I -> the I$ access completes. A subsequent I$ REN is never granted while the D$ flush writes are all served. Releasing halt lets I$ be granted.
- D$ REN & WEN together -> memory sees write only, and DUT_error = 1 for exactly one cycle after.
- Abort: D$ drops WEN mid-grant before mem_ready -> strobes zero that cycle, IDLE next, no wait/load completion. nRST pulse mid-GRANT_I -> IDLE, all strobes 0.
